// File: rtl/instr_encoder_stream_if.sv
// Handshake and payload bundle for instr_encoder_stream.
// master: field producer / word consumer side. slave: the encoder.
//   in_*  : decoded fields plus in_valid/in_ready handshake
//   out_* : packed word, load address, error flag plus out_valid/out_ready
interface instr_encoder_stream_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err
  );
endinterface

// File: rtl/instr_encoder_stream.sv
// Streaming RV32 instruction encoder: packs decoded fields into a 32-bit word,
// flags immediates that do not fit the format, and tags each delivered word
// with a sequential load address. Two-stage pipeline, one word per cycle.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : synchronous flush of pipeline, address and counters
//   bus         : slave side of instr_encoder_stream_if (fields in, word out)
//   enc_count   : delivered words, saturating
//   err_count   : delivered errored words, saturating
module instr_encoder_stream #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter bit                STRICT    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  instr_encoder_stream_if.slave   bus,
  output logic [15:0]             enc_count,
  output logic [15:0]             err_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} fmt_e;

  fmt_e        in_fmt;
  logic        in_legal;

  logic        s1_valid;
  fmt_e        s1_fmt;
  logic        s1_err;
  logic [6:0]  s1_op;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [2:0]  s1_f3;
  logic [6:0]  s1_f7;
  logic [31:0] s1_imm;

  logic [31:0] s1_word;
  logic        s2_load;
  logic        s2_adv;
  logic        in_hs;

  // Format selection and immediate representability, evaluated on the input fields.
  always_comb begin
    in_fmt = FMT_X;
    case (bus.in_opcode)
      7'b0010011, 7'b0000011, 7'b1100111: in_fmt = FMT_I;
      7'b0100011:                         in_fmt = FMT_S;
      7'b1100011:                         in_fmt = FMT_B;
      7'b0110111, 7'b0010111:             in_fmt = FMT_U;
      7'b1101111:                         in_fmt = FMT_J;
      7'b0110011:                         in_fmt = FMT_R;
      default:                            in_fmt = FMT_X;
    endcase

    in_legal = 1'b0;
    case (in_fmt)
      FMT_R:        in_legal = 1'b1;
      FMT_I, FMT_S: in_legal = (bus.in_imm == {{20{bus.in_imm[11]}}, bus.in_imm[11:0]});
      FMT_B:        in_legal = !bus.in_imm[0] &&
                               (bus.in_imm == {{19{bus.in_imm[12]}}, bus.in_imm[12:0]});
      FMT_J:        in_legal = !bus.in_imm[0] &&
                               (bus.in_imm == {{11{bus.in_imm[20]}}, bus.in_imm[20:0]});
      FMT_U:        in_legal = (bus.in_imm[11:0] == 12'd0);
      default:      in_legal = 1'b0;
    endcase
  end

  // Standard RV32 packing of the S1 contents; unsupported opcodes fall back to R layout.
  always_comb begin
    s1_word = {s1_f7, s1_rs2, s1_rs1, s1_f3, s1_rd, s1_op};
    case (s1_fmt)
      FMT_I: s1_word = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op};
      FMT_S: s1_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], s1_op};
      FMT_B: s1_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3,
                        s1_imm[4:1], s1_imm[11], s1_op};
      FMT_U: s1_word = {s1_imm[31:12], s1_rd, s1_op};
      FMT_J: s1_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_op};
      default: s1_word = {s1_f7, s1_rs2, s1_rs1, s1_f3, s1_rd, s1_op};
    endcase
    if (s1_err && STRICT) s1_word = NOP;
  end

  // S2 accepts when empty or draining; S1 moves exactly when S2 loads.
  assign s2_adv       = bus.out_valid && bus.out_ready;
  assign s2_load      = s1_valid && (!bus.out_valid || bus.out_ready);
  assign bus.in_ready = rst_n && !clear && (!s1_valid || s2_load);
  assign in_hs        = bus.in_valid && bus.in_ready;

  // Stage 1: registered fields plus format/legality result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_fmt   <= FMT_X;
      s1_err   <= 1'b0;
      s1_op    <= '0;
      s1_rd    <= '0;
      s1_rs1   <= '0;
      s1_rs2   <= '0;
      s1_f3    <= '0;
      s1_f7    <= '0;
      s1_imm   <= '0;
    end else if (clear) begin
      s1_valid <= 1'b0;
    end else if (in_hs) begin
      s1_valid <= 1'b1;
      s1_fmt   <= in_fmt;
      s1_err   <= !in_legal;
      s1_op    <= bus.in_opcode;
      s1_rd    <= bus.in_rd;
      s1_rs1   <= bus.in_rs1;
      s1_rs2   <= bus.in_rs2;
      s1_f3    <= bus.in_funct3;
      s1_f7    <= bus.in_funct7;
      s1_imm   <= bus.in_imm;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: output word, address and delivery counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_instr <= '0;
      bus.out_err   <= 1'b0;
      bus.out_addr  <= BASE_ADDR;
      enc_count     <= '0;
      err_count     <= '0;
    end else if (clear) begin
      bus.out_valid <= 1'b0;
      bus.out_addr  <= BASE_ADDR;
      enc_count     <= '0;
      err_count     <= '0;
    end else begin
      if (s2_load) begin
        bus.out_valid <= 1'b1;
        bus.out_instr <= s1_word;
        bus.out_err   <= s1_err;
      end else if (s2_adv) begin
        bus.out_valid <= 1'b0;
      end
      if (s2_adv) begin
        bus.out_addr <= bus.out_addr + ADDR_W'(4);
        if (enc_count != CNT_MAX) enc_count <= enc_count + 16'd1;
        if (bus.out_err && (err_count != CNT_MAX)) err_count <= err_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_stream.sv
`timescale 1ns/1ps
module tb_instr_encoder_stream;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  logic clear2;
  logic [15:0] enc_count, err_count, enc_count2, err_count2;

  always #5 clk = ~clk;

  instr_encoder_stream_if #(.ADDR_W(32)) bus ();
  instr_encoder_stream_if #(.ADDR_W(4))  bus2 ();

  instr_encoder_stream #(.ADDR_W(32), .BASE_ADDR(32'h0), .STRICT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus),
    .enc_count(enc_count), .err_count(err_count)
  );

  instr_encoder_stream #(.ADDR_W(4), .BASE_ADDR(4'h0), .STRICT(1'b0)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .clear(clear2), .bus(bus2),
    .enc_count(enc_count2), .err_count(err_count2)
  );

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_addr;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
    bus.in_opcode = op; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
    bus.in_funct3 = f3; bus.in_funct7 = f7; bus.in_imm = imm;
  endtask

  // One clock cycle on the main DUT: tracks both handshakes, checks each delivered word.
  task automatic cycle(input exp_t pend, output bit accepted);
    exp_t e;
    #1;
    accepted = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", bus.out_instr, 32'hxxxx_xxxx);
      end else begin
        e = exp_q.pop_front();
        chk("word_instr", bus.out_instr, e.instr);
        chk("word_err", 32'(bus.out_err), 32'(e.err));
        chk("word_addr", bus.out_addr, exp_addr);
        exp_addr = exp_addr + 32'd4;
      end
    end
    if (accepted) exp_q.push_back(pend);
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm, input logic [31:0] ei, input logic ee);
    exp_t p;
    bit   acc;
    p.instr = ei; p.err = ee;
    set_in(op, rd, rs1, rs2, f3, f7, imm);
    bus.in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) cycle(p, acc);
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    exp_t p;
    bit   acc;
    p.instr = '0; p.err = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle(p, acc);
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [31:0] w4_instr [5];
    logic [31:0] w4_imm   [5];

    rst_n = 1'b0; clear = 1'b0; clear2 = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    set_in(7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b1;
    bus2.in_opcode = 7'b0010011; bus2.in_rd = 5'd1; bus2.in_rs1 = 5'd0; bus2.in_rs2 = 5'd0;
    bus2.in_funct3 = 3'd0; bus2.in_funct7 = 7'd0; bus2.in_imm = 32'd0;
    exp_addr = 32'h0;

    // Reset values
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'h0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    chk("rst_out_addr", bus.out_addr, 32'h0);
    chk("rst_enc_count", 32'(enc_count), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADDI x1,x0,5 with 2-edge latency
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
    chk("addi_not_yet", 32'(bus.out_valid), 32'd0);
    drain();
    chk("addi_enc_count", 32'(enc_count), 32'd1);

    // Back-to-back mixed formats, one per cycle
    c0 = cyc;
    send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,          32'h0020_A423, 1'b0);
    send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC,  32'hFE20_8EE3, 1'b0);
    send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,       32'h0010_00EF, 1'b0);
    send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000,  32'h1234_52B7, 1'b0);
    drain();
    chk("b2b_cycles", 32'(cyc - c0), 32'd6);
    chk("b2b_enc_count", 32'(enc_count), 32'd5);
    chk("b2b_addr_next", bus.out_addr, 32'h14);

    // R-type ignores immediate
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF, 32'h4020_81B3, 1'b0);
    // Illegal immediates and opcode become NOP with error
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,       32'h0000_0013, 1'b1);
    send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3,          32'h0000_0013, 1'b1);
    send(7'b1111111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,          32'h0000_0013, 1'b1);
    drain();
    chk("err_count", 32'(err_count), 32'd3);
    chk("err_enc_count", 32'(enc_count), 32'd9);

    // Clear with two words buffered and a coincident output handshake
    bus.out_ready = 1'b0;
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 32'h0070_0093, 1'b0);
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h0080_0093, 1'b0);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1; clear = 1'b1;
    #1;
    chk("clear_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0; bus.in_valid = 1'b0;
    chk("clear_out_valid", 32'(bus.out_valid), 32'd0);
    chk("clear_out_addr", bus.out_addr, 32'h0);
    chk("clear_enc_count", 32'(enc_count), 32'd0);
    chk("clear_err_count", 32'(err_count), 32'd0);
    exp_q.delete(); exp_addr = 32'h0;

    // Back-pressure: two accepts then stall with stable output
    bus.out_ready = 1'b0;
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0010_0093, 1'b0);
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h0020_0093, 1'b0);
    set_in(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_out_instr", bus.out_instr, 32'h0010_0093);
      chk("stall_out_addr", bus.out_addr, 32'h0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0030_0093, 1'b0);
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, 32'h0040_0093, 1'b0);
    drain();
    chk("bp_enc_count", 32'(enc_count), 32'd4);
    chk("bp_addr_next", bus.out_addr, 32'h10);

    // Asynchronous reset mid-stream
    bus.out_ready = 1'b0;
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9, 32'h0090_0093, 1'b0);
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd10, 32'h00A0_0093, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_out_instr", bus.out_instr, 32'h0);
    chk("arst_out_addr", bus.out_addr, 32'h0);
    chk("arst_enc_count", 32'(enc_count), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.delete(); exp_addr = 32'h0;
    bus.out_ready = 1'b1;
    send(7'b0010011, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 32'h8000_8113, 1'b0);
    drain();

    // Narrow address wrap and STRICT=0 truncated packing
    w4_imm[0] = 32'd1;    w4_instr[0] = 32'h0010_0093;
    w4_imm[1] = 32'd2;    w4_instr[1] = 32'h0020_0093;
    w4_imm[2] = 32'd3;    w4_instr[2] = 32'h0030_0093;
    w4_imm[3] = 32'd4;    w4_instr[3] = 32'h0040_0093;
    w4_imm[4] = 32'd2048; w4_instr[4] = 32'h8000_0093;
    for (int c = 0; c < 6; c++) begin
      bus2.in_valid = (c < 5);
      if (c < 5) bus2.in_imm = w4_imm[c];
      @(posedge clk); #1;
      if (c >= 1) begin
        chk("w4_out_valid", 32'(bus2.out_valid), 32'd1);
        chk("w4_out_addr", 32'(bus2.out_addr), 32'((c - 1) * 4) & 32'hF);
        chk("w4_out_instr", bus2.out_instr, w4_instr[c-1]);
        chk("w4_out_err", 32'(bus2.out_err), (c == 5) ? 32'd1 : 32'd0);
      end
    end
    bus2.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("w4_enc_count", 32'(enc_count2), 32'd5);
    chk("w4_err_count", 32'(err_count2), 32'd1);

    // Counter saturation under a long continuous stream
    set_in(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 65600; i++) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("sat_enc_count", 32'(enc_count), 32'h0000_FFFF);
    chk("sat_err_count", 32'(err_count), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    chk("sat_enc_hold", 32'(enc_count), 32'h0000_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder_stream.md
Name: instr_encoder_stream

Overview:
- Streaming RISC-V RV32 instruction encoder. It is the inverse of the core's immediate generator.
- Accepts decoded fields (opcode, registers, funct, full 32-bit immediate) over a valid/ready handshake and packs them into a 32-bit instruction word.
- Checks that the immediate is representable in the selected format.
- Emits each word with a sequential load address for the instruction-memory loader and self-test sequencer.
- 2-stage pipeline, throughput 1 word/cycle.

Parameters:
- ADDR_W, 32, width of out_addr.
- BASE_ADDR, 0, out_addr value after reset or clear.
- STRICT, 1. 1: an errored word is replaced by NOP 0x00000013. 0: the truncated immediate bits are packed as-is.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush: pipeline, address and counters.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder can accept.
- in_opcode  in  7  opcode.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7 (R-type only).
- in_imm  in  32  signed byte-offset/immediate, as the core decodes it.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  load address of out_instr.
- out_err  out  1  immediate unrepresentable or opcode unsupported.
- enc_count  out  16  words delivered, saturating.
- err_count  out  16  errored words delivered, saturating.

Behaviour:
- Reset (async, rst_n=0): both stage valids 0, out_valid=0, out_instr=0, out_err=0, out_addr=BASE_ADDR, counters 0. in_ready=0 while rst_n=0.
- Format by opcode:
  - I: 0010011, 0000011, 1100111.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - R: 0110011; in_imm ignored, never errors.
  - Any other opcode: error.
- Packing, standard RV32:
  - I = imm[11:0]|rs1|f3|rd|op.
  - S = imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
  - B = imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
  - U = imm[31:12]|rd|op.
  - J = imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
  - R = f7|rs2|rs1|f3|rd|op.
- Legality:
  - I/S: in_imm equals the sign extension of in_imm[11:0].
  - B: in_imm[0]=0 and in_imm equals the sign extension of in_imm[12:0].
  - J: in_imm[0]=0 and in_imm equals the sign extension of in_imm[20:0].
  - U: in_imm[11:0]=0.
- Round-trip requirement: for every legal input, the core's immediate generator applied to out_instr returns in_imm exactly.
- Error handling: out_err=1. STRICT=1 gives out_instr=0x00000013; STRICT=0 gives the truncated packing.
- Pipeline:
  - S1 registers the fields and the format/legality result.
  - S2 registers out_instr and out_err.
  - Latency 2 cycles from in handshake to out_valid, with no back-pressure.
  - A stage loads when it is empty or its content moves on in the same cycle.
  - in_ready = !s1_valid || s1 advancing. in_ready is combinational from out_ready; it is not registered.
- Stall: while out_valid && !out_ready, out_instr, out_addr and out_err hold stable. No word is dropped, duplicated or reordered. At most 2 words are buffered.
- Output handshake (out_valid && out_ready):
  - out_addr += 4 on the following edge, wrapping modulo 2^ADDR_W.
  - enc_count += 1; err_count += 1 if out_err. Both saturate at 0xFFFF.
- clear=1:
  - in_ready=0 that cycle.
  - Next edge: both stages empty, out_addr=BASE_ADDR, counters 0.
  - A coincident output handshake is not counted.
- Reset mid-stream: buffered words are discarded. The first accepted word after release gets out_addr=BASE_ADDR.

Test Plan:
- ADDI x1,x0,5 (op 0010011, rd=1, f3=0, imm=5), out_ready=1 -> out_instr=0x00500093, out_addr=0x0, out_err=0, 2 cycles after accept.
- Back-to-back: SW x2,8(x1) -> 0x0020A423; BEQ x1,x2,imm=-4 -> 0xFE208EE3; JAL x1,imm=2048 -> 0x001000EF; LUI x5,imm=0x12345000 -> 0x123452B7. Expect one word per cycle, addresses 0x4/0x8/0xC/0x10, enc_count=5.
- Errors, STRICT=1:
  - ADDI imm=2048 -> 0x00000013, err=1.
  - BEQ imm=3 -> 0x00000013, err=1.
  - Opcode 1111111 -> 0x00000013, err=1.
  - Expect err_count=3.
- Back-pressure: push 4 words with out_ready=0 for 6 cycles -> in_ready falls after 2 accepts and first output held stable; release -> words in order at 0x0,0x4,0x8,0xC.
- Clear and reset: clear with 2 words buffered -> out_valid=0 next cycle, out_addr=BASE_ADDR, counters 0. rst_n pulse mid-stream -> all outputs at reset values asynchronously.
- Wrap/saturation: ADDR_W=4, 5 words -> addresses 0,4,8,C,0. Force enc_count to 0xFFFF -> stays 0xFFFF.
